// File: rtl/parity_frame_acc_pkg.sv
// Shared types for the parity frame accumulator.
// Holds the FSM state enum and the default frame length.
package parity_frame_pkg;

  localparam int FRAME_LEN_DEF = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/parity_frame_acc_if.sv
// Handshake bundle between XOR stage, accumulator and sink.
// master: drives in_valid/in_bit/flush/out_ready; slave: the accumulator.
interface parity_frame_acc_if #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
);

  logic                 in_valid;
  logic                 in_bit;
  logic                 in_ready;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [FRAME_LEN-1:0] out_data;
  logic [CNT_W-1:0]     out_len;
  logic                 out_parity;

  modport master (
    output in_valid, in_bit, flush, out_ready,
    input  in_ready, out_valid, out_data, out_len, out_parity
  );

  modport slave (
    input  in_valid, in_bit, flush, out_ready,
    output in_ready, out_valid, out_data, out_len, out_parity
  );

endinterface

// File: rtl/parity_frame_acc_shifter.sv
// Frame datapath: bit store, fill count and running parity.
// Ports: clk, rst, load+bit_in (append), clear, data/count/parity/last.
module frame_shifter #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 bit_in,
  input  logic                 clear,
  output logic [FRAME_LEN-1:0] data,
  output logic [CNT_W-1:0]     count,
  output logic                 parity,
  output logic                 last
);

  // Next append fills the final slot of the frame.
  assign last = (count == CNT_W'(FRAME_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data   <= '0;
      count  <= '0;
      parity <= 1'b0;
    end else if (clear) begin
      data   <= '0;
      count  <= '0;
      parity <= 1'b0;
    end else if (load) begin
      // Slots above count are always zero, so OR-in is a write.
      data   <= data | (FRAME_LEN'(bit_in) << count);
      count  <= count + CNT_W'(1);
      parity <= parity ^ bit_in;
    end
  end

endmodule

// File: rtl/parity_frame_acc.sv
// Packs XOR-stage bits into frames with length and parity.
// Ports: clk, rst, bus (slave handshake bundle), frame_cnt (handoffs).
module parity_frame_acc
  import parity_frame_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  parity_frame_acc_if.slave   bus,
  output logic [7:0]          frame_cnt
);

  state_t               state;
  logic                 accept;
  logic                 handoff;
  logic                 emit;
  logic [FRAME_LEN-1:0] sh_data;
  logic [CNT_W-1:0]     sh_count;
  logic                 sh_parity;
  logic                 sh_last;

  assign accept  = bus.in_valid & (state == ACCUM);
  assign handoff = bus.out_ready & (state == HOLD);

  // A flush on an empty frame is dropped unless a beat lands too.
  assign emit = (accept & (sh_last | bus.flush))
              | (bus.flush & (sh_count != '0));

  frame_shifter #(
    .FRAME_LEN(FRAME_LEN),
    .CNT_W    (CNT_W)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .bit_in(bus.in_bit),
    .clear (handoff),
    .data  (sh_data),
    .count (sh_count),
    .parity(sh_parity),
    .last  (sh_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      frame_cnt <= 8'd0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (emit) state <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            state     <= ACCUM;
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign bus.in_ready   = (state == ACCUM);
  assign bus.out_valid  = (state == HOLD);
  assign bus.out_data   = sh_data;
  assign bus.out_len    = sh_count;
  assign bus.out_parity = sh_parity;

endmodule

// File: tb/tb_parity_frame_acc.sv
// Scoreboard bench for parity_frame_acc.
// Expected frames are queued at stimulus time, popped on handoff.
module tb_parity_frame_acc;

  localparam int FL = 8;
  localparam int CW = $clog2(FL + 1);

  typedef struct {
    logic [FL-1:0] data;
    logic [CW-1:0] len;
    logic          par;
  } frame_t;

  logic       clk;
  logic       rst;
  logic [7:0] frame_cnt;
  logic       u, v;

  parity_frame_acc_if #(.FRAME_LEN(FL)) bus ();

  parity_frame_acc #(.FRAME_LEN(FL)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  frame_t        sbq[$];
  logic [FL-1:0] mdata;
  int            mlen;
  logic          mpar;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mdata = '0;
    mlen  = 0;
    mpar  = 1'b0;
  endtask

  task automatic model_push();
    frame_t f;
    f.data = mdata;
    f.len  = CW'(mlen);
    f.par  = mpar;
    sbq.push_back(f);
    model_clear();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 100) chk("rdy_timeout", 0, 1);
  endtask

  task automatic beat(input logic b, input logic fl);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.flush    = fl;
    mdata[mlen]  = b;
    mpar         = mpar ^ b;
    mlen++;
    if (mlen == FL || fl) model_push();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic do_flush();
    wait_ready();
    bus.flush = 1'b1;
    if (mlen > 0) model_push();
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 100) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    model_clear();
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        frame_t f;
        f = sbq.pop_front();
        chk("sb_data", bus.out_data, f.data);
        chk("sb_len", bus.out_len, f.len);
        chk("sb_par", bus.out_parity, f.par);
      end
    end
  end

  logic [7:0] pat;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    u = 1'b0;
    v = 1'b0;
    model_clear();
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_len", bus.out_len, 0);
    chk("rst_out_par", bus.out_parity, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full frame 1,0,1,1,0,0,0,1 with sink ready
    bus.out_ready = 1'b1;
    pat = 8'b1000_1101;
    for (int i = 0; i < FL; i++) beat(pat[i], 1'b0);
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_in_ready", bus.in_ready, 0);
    chk("t1_data", bus.out_data, 8'h8D);
    chk("t1_len", bus.out_len, 8);
    chk("t1_par", bus.out_parity, 0);
    @(posedge clk); #1;
    chk("t1_dead_ready", bus.in_ready, 1);
    chk("t1_cnt", frame_cnt, 1);

    // Back-to-back 1,1,1 with flush on the third beat
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b1);
    chk("t2_valid", bus.out_valid, 1);
    chk("t2_data", bus.out_data, 8'h07);
    chk("t2_len", bus.out_len, 3);
    chk("t2_par", bus.out_parity, 1);
    drain();
    chk("t2_cnt", frame_cnt, 2);

    // Sink stalls 5 cycles on a full frame
    bus.out_ready = 1'b0;
    pat = 8'hA5;
    for (int i = 0; i < FL; i++) beat(pat[i], 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_valid", bus.out_valid, 1);
      chk("t3_in_ready", bus.in_ready, 0);
      chk("t3_data", bus.out_data, 8'hA5);
      chk("t3_len", bus.out_len, 8);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_handoff", bus.in_ready, 1);
    chk("t3_cnt", frame_cnt, 3);

    // Flush in HOLD is ignored
    bus.out_ready = 1'b0;
    for (int i = 0; i < FL; i++) beat(1'b0, 1'b0);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("t4_hold_valid", bus.out_valid, 1);
    chk("t4_hold_len", bus.out_len, 8);
    bus.out_ready = 1'b1;
    drain();

    // Reset mid-frame discards the partial frame
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b0);
    rst = 1'b1;
    #2;
    chk("t5_len", bus.out_len, 0);
    chk("t5_valid", bus.out_valid, 0);
    chk("t5_data", bus.out_data, 0);
    chk("t5_cnt", frame_cnt, 0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    pat = 8'h3C;
    for (int i = 0; i < FL; i++) beat(pat[i], 1'b0);
    chk("t5_new_len", bus.out_len, 8);
    chk("t5_new_data", bus.out_data, 8'h3C);
    drain();
    chk("t5_new_cnt", frame_cnt, 1);

    // XOR stage upstream, u=1 v=0 every beat
    u = 1'b1;
    v = 1'b0;
    for (int i = 0; i < FL; i++) beat(u ^ v, 1'b0);
    chk("t6_data", bus.out_data, 8'hFF);
    chk("t6_par", bus.out_parity, 0);
    drain();

    // Empty flush ignored, then frame counter wrap
    pulse_rst();
    do_flush();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t7_no_frame", bus.out_valid, 0);
    end
    for (int f = 0; f < 257; f++) begin
      for (int i = 0; i < FL; i++) beat(1'($urandom_range(1)), 1'b0);
      if (f == 255) begin
        drain();
        chk("t7_wrap0", frame_cnt, 0);
      end
    end
    drain();
    chk("t7_wrap1", frame_cnt, 1);
    chk("t7_sb_left", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_frame_acc.md
PARITY_FRAME_ACC -- requirements
Module: parity_frame_acc

Interface
REQ-001 Parameter FRAME_LEN, default 8, number of bits per frame (legal range 2..32).
REQ-002 Parameter CNT_W, default $clog2(FRAME_LEN+1), width of the length fields.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  upstream XOR-stage bit valid.
REQ-007 in_bit  input  1  the bit produced by the upstream XOR stage (a ^ b).
REQ-008 in_ready  output  1  block accepts in_bit this cycle.
REQ-009 flush  input  1  single-cycle request to emit a partial frame.
REQ-010 out_valid  output  1  a frame is presented.
REQ-011 out_ready  input  1  downstream accepts the frame.
REQ-012 out_data  output  FRAME_LEN  frame bits; first accepted bit in bit 0.
REQ-013 out_len  output  CNT_W  number of valid bits in out_data.
REQ-014 out_parity  output  1  XOR of all valid bits in out_data.
REQ-015 frame_cnt  output  8  count of frames handed off; wraps 255->0.

Function
REQ-016 States: ACCUM (collecting) and HOLD (frame presented); no other states.
REQ-017 ACCUM: in_ready=1 and out_valid=0; HOLD: in_ready=0 and out_valid=1.
REQ-018 Beat accepted when in_valid&in_ready: in_bit written to data[count], parity^=in_bit, count+=1.
REQ-019 An accepted beat making count==FRAME_LEN SHALL move to HOLD in the next cycle with out_len=FRAME_LEN.
REQ-020 flush in ACCUM with count>0 SHALL move to HOLD with out_len=count; unfilled data bits SHALL be 0.
REQ-021 flush and an accepted beat in the same cycle: the beat is included first, then the frame is emitted (out_len=count+1).
REQ-022 flush in ACCUM with count==0 and no accepted beat SHALL be ignored (no empty frames).
REQ-023 flush in HOLD SHALL be ignored.
REQ-024 HOLD with out_ready=1 SHALL complete the handoff: next state ACCUM, count=0, parity=0, data=0, frame_cnt+=1 (mod 256).
REQ-025 out_data, out_len and out_parity SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 Latency: last beat accepted in cycle N -> out_valid=1 in cycle N+1; after handoff in cycle M, in_ready=1 in cycle M+1 (one dead cycle per frame).
REQ-027 out_valid SHALL NOT depend combinationally on out_ready; in_ready SHALL NOT depend combinationally on in_valid.

Reset
REQ-028 Asserting rst SHALL immediately force state=ACCUM, count=0, parity=0, data=0, frame_cnt=0.
REQ-029 Output values during and after reset: in_ready=1, out_valid=0, out_data=0, out_len=0, out_parity=0, frame_cnt=0.
REQ-030 Reset mid-frame or in HOLD SHALL discard the partial/presented frame without a handoff.

Structure
REQ-031 Package parity_frame_pkg SHALL hold the state enum (ACCUM, HOLD) and the default FRAME_LEN constant.
REQ-032 One sub-module, frame_shifter, SHALL hold data/count/parity with load, clear and flush-length controls; parity_frame_acc holds the FSM and frame_cnt.
REQ-033 The block SHALL elaborate, flatten and equivalence-check cleanly in the existing hierarchy/flatten test flow.

Verification
REQ-034 Reset then 8 beats 1,0,1,1,0,0,0,1 with out_ready=1 -> out_data=8'h8D, out_len=8, out_parity=0, frame_cnt=1 after handoff.
REQ-035 Back-to-back beats 1,1,1 then flush on third beat -> out_data=8'h07, out_len=3, out_parity=1.
REQ-036 Full frame, out_ready held 0 for 5 cycles -> out_valid and out_data stable, in_ready=0 throughout; handoff on the 6th cycle.
REQ-037 flush at count==0 -> no out_valid; then 255+2 full frames -> frame_cnt wraps to 1.
REQ-038 rst asserted after 4 beats -> count cleared, out_valid=0; next 8 beats form a fresh frame with out_len=8.
REQ-039 Upstream driven by a bound XOR stage (u=1,v=0 every beat) -> out_data=8'hFF, out_parity=0.
